// File: rtl/isa_xcvr_cycle_ctrl_pkg.sv
// Shared encodings for the ISA/CAMAC transceiver sequencer and the IC82x6 benches.
package isa_xcvr_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_REQ   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_TURN  = 3'd4
  } state_t;

  localparam logic DCE_READ  = 1'b0;
  localparam logic DCE_WRITE = 1'b1;
  localparam logic CS_OFF    = 1'b1;

endpackage

// File: rtl/isa_xcvr_cycle_ctrl_if.sv
// ISA strobes, local-side handshake and IC82x6 control lines of one transceiver pair.
interface isa_xcvr_cycle_ctrl_if;

  logic ior_n;
  logic iow_n;
  logic aen;
  logic addr_hit;
  logic loc_ack;
  logic loc_req;
  logic loc_wr;
  logic xcvr_cs_n;
  logic xcvr_dce;
  logic iochrdy;
  logic busy;
  logic timeout_err;

  modport master (
    input  ior_n, iow_n, aen, addr_hit, loc_ack,
    output loc_req, loc_wr, xcvr_cs_n, xcvr_dce, iochrdy, busy, timeout_err
  );

  modport slave (
    output ior_n, iow_n, aen, addr_hit, loc_ack,
    input  loc_req, loc_wr, xcvr_cs_n, xcvr_dce, iochrdy, busy, timeout_err
  );

endinterface

// File: rtl/isa_xcvr_cycle_ctrl_sync_2ff.sv
// Generic 1-bit two-flop synchroniser; resets to 1 so idle-high strobes read inactive.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/isa_xcvr_cycle_ctrl.sv
// Sequences IC82x6 direction/enable around an addressed ISA I/O cycle and the local req/ack handshake.
module isa_xcvr_cycle_ctrl
  import isa_xcvr_cycle_ctrl_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int TURN_CYCLES  = 1,
  parameter int ACK_TIMEOUT  = 64,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  isa_xcvr_cycle_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST    = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic ior_sync_n;
  logic iow_sync_n;
  logic rd_s;
  logic wr_s;
  logic start;
  logic strobe_on;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             loc_req_q;
  logic             loc_wr_q;
  logic             cs_n_q;
  logic             dce_q;
  logic             iochrdy_q;
  logic             busy_q;
  logic             timeout_err_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sync_2ff u_sync_ior (.clk(clk), .rst_n(rst_n), .d(bus.ior_n), .q(ior_sync_n));
  sync_2ff u_sync_iow (.clk(clk), .rst_n(rst_n), .d(bus.iow_n), .q(iow_sync_n));

  assign rd_s = ~ior_sync_n;
  assign wr_s = ~iow_sync_n;

  // Both strobes low at once is a malformed cycle and never starts a transfer.
  assign start     = (rd_s ^ wr_s) && !bus.aen && bus.addr_hit && !bus.loc_ack;
  assign strobe_on = loc_wr_q ? wr_s : rd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      loc_req_q     <= 1'b0;
      loc_wr_q      <= 1'b0;
      cs_n_q        <= CS_OFF;
      dce_q         <= DCE_READ;
      iochrdy_q     <= 1'b1;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SETUP;
            cnt       <= '0;
            loc_wr_q  <= wr_s;
            dce_q     <= wr_s;
            iochrdy_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt >= SETUP_LAST) begin
            state     <= ST_REQ;
            cnt       <= '0;
            cs_n_q    <= 1'b0;
            loc_req_q <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        // Abort beats ack, ack beats timeout when they land in the same cycle.
        ST_REQ: begin
          if (!strobe_on) begin
            state     <= ST_TURN;
            cnt       <= '0;
            loc_req_q <= 1'b0;
            cs_n_q    <= CS_OFF;
            iochrdy_q <= 1'b1;
          end else if (bus.loc_ack) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            loc_req_q <= 1'b0;
            iochrdy_q <= 1'b1;
          end else if (cnt >= TIMEOUT_LAST) begin
            state         <= ST_HOLD;
            cnt           <= '0;
            loc_req_q     <= 1'b0;
            iochrdy_q     <= 1'b1;
            timeout_err_q <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_HOLD: begin
          if (!strobe_on) begin
            state  <= ST_TURN;
            cnt    <= '0;
            cs_n_q <= CS_OFF;
          end
        end
        // dce only falls once cs_n has been off for TURN_CYCLES; a late ack just parks here.
        ST_TURN: begin
          if (cnt >= TURN_LAST) begin
            dce_q <= DCE_READ;
            if (!bus.loc_ack) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.loc_req     = loc_req_q;
  assign bus.loc_wr      = loc_wr_q;
  assign bus.xcvr_cs_n   = cs_n_q;
  assign bus.xcvr_dce    = dce_q;
  assign bus.iochrdy     = iochrdy_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_isa_xcvr_cycle_ctrl.sv
// Directed bench for isa_xcvr_cycle_ctrl with a behavioural IC82x6 data path on the transceiver lines.
module tb_isa_xcvr_cycle_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [3:0] d_in;
  logic [3:0] isa_wdata;
  logic [3:0] d_bus;
  logic [3:0] d_out;

  isa_xcvr_cycle_ctrl_if bus ();

  isa_xcvr_cycle_ctrl #(
    .SETUP_CYCLES(1),
    .TURN_CYCLES (1),
    .ACK_TIMEOUT (8),
    .CNT_W       (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // IC82x6 pair: drives the ISA bus on reads, the local side on writes, only while selected.
  assign d_bus = (!bus.xcvr_cs_n && !bus.xcvr_dce) ? d_in      : 4'h0;
  assign d_out = (!bus.xcvr_cs_n &&  bus.xcvr_dce) ? isa_wdata : 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},    32'(bus.busy),      32'd0);
    chk({tag, "_cs_n"},    32'(bus.xcvr_cs_n), 32'd1);
    chk({tag, "_iochrdy"}, 32'(bus.iochrdy),   32'd1);
    chk({tag, "_loc_req"}, 32'(bus.loc_req),   32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    d_in = 4'b0101;
    isa_wdata = 4'b1001;
    bus.ior_n = 1'b1;
    bus.iow_n = 1'b1;
    bus.aen = 1'b0;
    bus.addr_hit = 1'b1;
    bus.loc_ack = 1'b0;
    rst_n = 1'b0;

    #12;
    chk_idle("rst");
    chk("rst_dce",     32'(bus.xcvr_dce),    32'd0);
    chk("rst_loc_wr",  32'(bus.loc_wr),      32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Read cycle with ack five cycles after the strobe.
    bus.ior_n = 1'b0;
    tick(3);
    chk("rd_setup_iochrdy", 32'(bus.iochrdy),   32'd0);
    chk("rd_setup_cs_n",    32'(bus.xcvr_cs_n), 32'd1);
    chk("rd_setup_dce",     32'(bus.xcvr_dce),  32'd0);
    chk("rd_setup_busy",    32'(bus.busy),      32'd1);
    tick(1);
    chk("rd_req_cs_n",    32'(bus.xcvr_cs_n), 32'd0);
    chk("rd_req_loc_req", 32'(bus.loc_req),   32'd1);
    chk("rd_req_dce",     32'(bus.xcvr_dce),  32'd0);
    chk("rd_req_d_bus",   32'(d_bus),         32'h5);
    chk("rd_req_loc_wr",  32'(bus.loc_wr),    32'd0);
    tick(2);
    chk("rd_wait_iochrdy", 32'(bus.iochrdy), 32'd0);
    bus.loc_ack = 1'b1;
    tick(1);
    chk("rd_ack_iochrdy", 32'(bus.iochrdy),   32'd1);
    chk("rd_ack_loc_req", 32'(bus.loc_req),   32'd0);
    chk("rd_hold_cs_n",   32'(bus.xcvr_cs_n), 32'd0);
    chk("rd_hold_d_bus",  32'(d_bus),         32'h5);
    bus.loc_ack = 1'b0;
    tick(1);
    chk("rd_hold2_cs_n", 32'(bus.xcvr_cs_n), 32'd0);
    bus.ior_n = 1'b1;
    tick(3);
    chk("rd_turn_cs_n", 32'(bus.xcvr_cs_n), 32'd1);
    chk("rd_turn_dce",  32'(bus.xcvr_dce),  32'd0);
    chk("rd_turn_busy", 32'(bus.busy),      32'd1);
    tick(1);
    chk_idle("rd_end");
    tick(2);

    // Write cycle, ack held late through TURN.
    bus.iow_n = 1'b0;
    tick(3);
    chk("wr_setup_dce",    32'(bus.xcvr_dce),  32'd1);
    chk("wr_setup_cs_n",   32'(bus.xcvr_cs_n), 32'd1);
    chk("wr_setup_loc_wr", 32'(bus.loc_wr),    32'd1);
    tick(1);
    chk("wr_req_cs_n",  32'(bus.xcvr_cs_n), 32'd0);
    chk("wr_req_dce",   32'(bus.xcvr_dce),  32'd1);
    chk("wr_req_d_out", 32'(d_out),         32'h9);
    bus.loc_ack = 1'b1;
    tick(1);
    chk("wr_ack_iochrdy", 32'(bus.iochrdy), 32'd1);
    chk("wr_ack_loc_req", 32'(bus.loc_req), 32'd0);
    bus.iow_n = 1'b1;
    tick(3);
    chk("wr_turn_cs_n", 32'(bus.xcvr_cs_n), 32'd1);
    chk("wr_turn_dce",  32'(bus.xcvr_dce),  32'd1);
    tick(1);
    chk("wr_turn2_dce",  32'(bus.xcvr_dce), 32'd0);
    chk("wr_turn2_busy", 32'(bus.busy),     32'd1);
    bus.loc_ack = 1'b0;
    tick(1);
    chk_idle("wr_end");
    tick(2);

    // Filtering: DMA cycle, address miss, both strobes low.
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin bus.aen = 1'b1; bus.ior_n = 1'b0; end
        1: begin bus.addr_hit = 1'b0; bus.iow_n = 1'b0; end
        default: begin bus.ior_n = 1'b0; bus.iow_n = 1'b0; end
      endcase
      tick(6);
      chk_idle($sformatf("filt%0d", c));
      bus.ior_n = 1'b1;
      bus.iow_n = 1'b1;
      tick(4);
      bus.aen = 1'b0;
      bus.addr_hit = 1'b1;
      tick(1);
    end

    // Ack never arrives: forced completion after 8 REQ cycles.
    bus.ior_n = 1'b0;
    tick(4);
    chk("to_req_loc_req", 32'(bus.loc_req), 32'd1);
    tick(7);
    chk("to_early_err",     32'(bus.timeout_err), 32'd0);
    chk("to_early_loc_req", 32'(bus.loc_req),     32'd1);
    chk("to_early_iochrdy", 32'(bus.iochrdy),     32'd0);
    tick(1);
    chk("to_err",     32'(bus.timeout_err), 32'd1);
    chk("to_loc_req", 32'(bus.loc_req),     32'd0);
    chk("to_iochrdy", 32'(bus.iochrdy),     32'd1);
    chk("to_cs_n",    32'(bus.xcvr_cs_n),   32'd0);
    tick(1);
    chk("to_err_once", 32'(bus.timeout_err), 32'd0);
    chk("to_hold_cs_n", 32'(bus.xcvr_cs_n),  32'd0);
    bus.ior_n = 1'b1;
    tick(3);
    chk("to_turn_cs_n", 32'(bus.xcvr_cs_n), 32'd1);
    tick(1);
    chk_idle("to_end");
    tick(2);

    // ISA abort during REQ, coinciding with an ack: abort must win.
    bus.ior_n = 1'b0;
    tick(5);
    bus.ior_n = 1'b1;
    tick(2);
    chk("ab_req_loc_req", 32'(bus.loc_req),   32'd1);
    chk("ab_req_cs_n",    32'(bus.xcvr_cs_n), 32'd0);
    bus.loc_ack = 1'b1;
    tick(1);
    chk("ab_loc_req", 32'(bus.loc_req),     32'd0);
    chk("ab_cs_n",    32'(bus.xcvr_cs_n),   32'd1);
    chk("ab_iochrdy", 32'(bus.iochrdy),     32'd1);
    chk("ab_err",     32'(bus.timeout_err), 32'd0);
    tick(1);
    chk("ab_late_ack_busy", 32'(bus.busy), 32'd1);
    bus.loc_ack = 1'b0;
    tick(1);
    chk_idle("ab_end");
    tick(2);

    // Asynchronous reset while in HOLD.
    bus.ior_n = 1'b0;
    tick(4);
    bus.loc_ack = 1'b1;
    tick(1);
    chk("rh_hold_cs_n", 32'(bus.xcvr_cs_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rh_async");
    chk("rh_async_dce",    32'(bus.xcvr_dce), 32'd0);
    chk("rh_async_loc_wr", 32'(bus.loc_wr),   32'd0);
    bus.ior_n = 1'b1;
    bus.loc_ack = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk_idle("rh_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/isa_xcvr_cycle_ctrl.md
Name: isa_xcvr_cycle_ctrl

Overview:
- Sequences the pair of 4-bit IC82x6 bus transceivers that form the 8-bit ISA data path of the sm2201 interface board.
- Detects an addressed ISA I/O read or write and sets transceiver direction (dce) before enabling them (cs_n).
- Runs a 4-phase req/ack handshake with the CAMAC-side local logic and holds IOCHRDY low until that side completes.
- Sits between the ISA address decoder and the IC82x6 instances.

Parameters:
- SETUP_CYCLES, 1: clk cycles dce is held stable with cs_n=1 before cs_n asserts (min 1).
- TURN_CYCLES, 1: clk cycles cs_n=1 is held before dce may return to 0 / IDLE (min 1).
- ACK_TIMEOUT, 64: max clk cycles waiting for loc_ack before a forced cycle completion.
- CNT_W, 8: internal counter width; must hold max(SETUP_CYCLES, TURN_CYCLES, ACK_TIMEOUT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ior_n  in  1  ISA IOR#, asynchronous to clk
- iow_n  in  1  ISA IOW#, asynchronous to clk
- aen  in  1  ISA AEN; 1 = DMA cycle, ignore
- addr_hit  in  1  decoder match, stable while strobe low
- loc_ack  in  1  local-side acknowledge
- loc_req  out  1  local-side request
- loc_wr  out  1  1 = write (ISA->local), 0 = read
- xcvr_cs_n  out  1  to IC82x6 cs_n, both nibbles
- xcvr_dce  out  1  to IC82x6 dce; 0 = d_in->d_bus (ISA read), 1 = d_bus->d_out (ISA write)
- iochrdy  out  1  1 = ready, 0 = extend ISA cycle
- busy  out  1  1 whenever state != IDLE
- timeout_err  out  1  1-cycle pulse on ack timeout

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: xcvr_cs_n=1, xcvr_dce=0, iochrdy=1, loc_req=0, loc_wr=0, busy=0, timeout_err=0, state=IDLE, counter=0, sync flops=1.
- Reset asserted mid-cycle: all outputs go immediately to their reset values, with no handshake completion.
- Synchronisation: ior_n and iow_n each pass through a 2-flop synchroniser. rd_s and wr_s are the inverted, synchronised strobes.
- All outputs are registered.
- IDLE:
  - cs_n=1, dce=0, iochrdy=1.
  - Start condition: exactly one of rd_s/wr_s is 1, aen=0, addr_hit=1, and loc_ack=0.
  - On start: latch loc_wr=wr_s, clear the counter, go to SETUP.
  - rd_s and wr_s both 1: ignored, stay in IDLE.
- SETUP:
  - iochrdy=0 from the first SETUP cycle; dce=loc_wr; cs_n stays 1.
  - After SETUP_CYCLES cycles go to REQ.
- REQ:
  - cs_n=0, loc_req=1, the counter increments.
  - loc_ack=1: loc_req=0 next cycle, go to HOLD.
  - Counter reaches ACK_TIMEOUT: pulse timeout_err, loc_req=0, go to HOLD.
  - Strobe for the latched direction deasserts (ISA abort): loc_req=0, go to TURN.
  - Precedence when events coincide: abort > ack > timeout.
- HOLD:
  - iochrdy=1, cs_n=0, dce unchanged.
  - Stay until the latched strobe deasserts, then go to TURN.
- TURN:
  - cs_n=1 on entry; dce holds its value for TURN_CYCLES cycles, then dce=0.
  - Go to IDLE only when loc_ack=0. Late-ack wait has no timeout.
- Invariants:
  - xcvr_dce never changes in a cycle where xcvr_cs_n=0, or in the cycle cs_n changes.
  - loc_req never re-asserts before loc_ack has been seen low.
  - iochrdy low for at most SETUP_CYCLES + ACK_TIMEOUT + 2 cycles.
- Latency: strobe edge to cs_n=0 is 2 (sync) + 1 + SETUP_CYCLES clk cycles.
- Counter: saturating, CNT_W bits, cleared on every state transition.

Decomposition:
- Shared package / include file (isa_camac_defs): state encodings (IDLE=0, SETUP=1, REQ=2, HOLD=3, TURN=4, 3-bit), the DCE_READ=0 / DCE_WRITE=1 constants, and the CS_OFF=1 constant. These are reused by the IC82x6 benches.
- One sub-module: sync_2ff, a generic 1-bit two-flop synchroniser with reset value 1, instantiated for ior_n and iow_n.

Test Plan:
- Read, SETUP=1: ior_n low, addr_hit=1, loc_ack after 5 cycles.
  - Required: dce=0 throughout, cs_n=0 at sync+2, iochrdy 0→1 one cycle after ack.
  - Required: cs_n=1 after ior_n rises, IDLE after TURN=1 and ack low.
  - Bench drives IC82x6 d_in=4'b0101 and checks d_bus=4'b0101 while cs_n=0.
- Write: iow_n low, bench drives d_bus=4'b1001.
  - Required: dce=1 a full SETUP cycle before cs_n=0, d_out=4'b1001 while cs_n=0, loc_wr=1.
  - Required: dce returns to 0 only after cs_n=1 plus TURN_CYCLES.
- Filtering: aen=1, or addr_hit=0, or ior_n and iow_n both low.
  - Required: state stays IDLE, cs_n=1, iochrdy=1, loc_req=0.
- Timeout, ACK_TIMEOUT=8: loc_ack never asserted.
  - Required: timeout_err pulses once after 8 REQ cycles, iochrdy=1, cycle completes when strobe rises.
- Abort: ior_n rises during REQ.
  - Required: loc_req drops, cs_n=1 next cycle, IDLE once loc_ack=0.
  - Then rst_n pulsed low during HOLD: all outputs return to reset values asynchronously.
